operand_b_stage: RTL

Registered operand-B stage for the RV32I pipeline, sitting between decode and the ALU at the ID/EX boundary. It decodes every immediate format (I, S, B, U, J) directly from the raw instruction word and sign-extends it to XLEN. It resolves rs2 forwarding from the EX/MEM and MEM/WB stages and selects the ALU operand B. It also registers a separate store-data output, with a valid/ready handshake, stall hold and synchronous flush.

---
 rtl/operand_b_stage_if.sv | 34 +++
 rtl/operand_b_stage.sv | 94 +++++++++
 2 files changed

// File: rtl/operand_b_stage_if.sv
// Handshake and datapath bundle between decode and the ALU operand-B register stage.
// The slave modport is the stage itself; the master modport is the decode/EX side.
interface operand_b_stage_if #(
   parameter int XLEN = 32
);
   logic            valid_in;
   logic            ready_out;
   logic [31:0]     instr_in;
   logic [2:0]      imm_fmt_in;
   logic            imm_sel_in;
   logic [1:0]      fwd_sel_in;
   logic [XLEN-1:0] rs2_data_in;
   logic [XLEN-1:0] exmem_result_in;
   logic [XLEN-1:0] memwb_result_in;
   logic            flush_in;
   logic            valid_out;
   logic            ready_in;
   logic [XLEN-1:0] op_b_out;
   logic [XLEN-1:0] store_data_out;
   logic            imm_fmt_err_out;
   logic [XLEN-1:0] trace_imm;

   modport master (
      output valid_in, instr_in, imm_fmt_in, imm_sel_in, fwd_sel_in,
             rs2_data_in, exmem_result_in, memwb_result_in, flush_in, ready_in,
      input  ready_out, valid_out, op_b_out, store_data_out, imm_fmt_err_out, trace_imm
   );

   modport slave (
      input  valid_in, instr_in, imm_fmt_in, imm_sel_in, fwd_sel_in,
             rs2_data_in, exmem_result_in, memwb_result_in, flush_in, ready_in,
      output ready_out, valid_out, op_b_out, store_data_out, imm_fmt_err_out, trace_imm
   );
endinterface

// File: rtl/operand_b_stage.sv
// ID/EX operand-B register: RV32I immediate decode, rs2 forwarding, operand-B select,
// and a registered store-data path behind a valid/ready handshake with stall and flush.
module operand_b_stage #(
   parameter int XLEN   = 32,
   parameter bit FWD_EN = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   operand_b_stage_if.slave  bus
);
   localparam logic [2:0] FMT_I = 3'd0;
   localparam logic [2:0] FMT_S = 3'd1;
   localparam logic [2:0] FMT_B = 3'd2;
   localparam logic [2:0] FMT_U = 3'd3;
   localparam logic [2:0] FMT_J = 3'd4;

   logic signed [31:0] imm32;
   logic [XLEN-1:0]    imm;
   logic               fmt_err;
   logic [XLEN-1:0]    fwd_rs2;
   logic               load;

   logic               valid_q;
   logic [XLEN-1:0]    op_b_q;
   logic [XLEN-1:0]    store_q;
   logic [XLEN-1:0]    imm_q;
   logic               err_q;

   // The opcode field never contributes to an immediate.
   logic unused_opcode;
   assign unused_opcode = ^bus.instr_in[6:0];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      imm32   = '0;
      fmt_err = 1'b0;
      case (bus.imm_fmt_in)
         FMT_I: imm32 = {{20{bus.instr_in[31]}}, bus.instr_in[31:20]};
         FMT_S: imm32 = {{20{bus.instr_in[31]}}, bus.instr_in[31:25], bus.instr_in[11:7]};
         FMT_B: imm32 = {{19{bus.instr_in[31]}}, bus.instr_in[31], bus.instr_in[7],
                         bus.instr_in[30:25], bus.instr_in[11:8], 1'b0};
         FMT_U: imm32 = {bus.instr_in[31:12], 12'b0};
         FMT_J: imm32 = {{11{bus.instr_in[31]}}, bus.instr_in[31], bus.instr_in[19:12],
                         bus.instr_in[20], bus.instr_in[30:21], 1'b0};
         default: fmt_err = 1'b1;
      endcase
   end

   // Signed size cast extends bit 31 out to the full datapath width.
   assign imm = XLEN'(imm32);

   always_comb begin
      fwd_rs2 = bus.rs2_data_in;
      if (FWD_EN) begin
         case (bus.fwd_sel_in)
            2'b01:   fwd_rs2 = bus.exmem_result_in;
            2'b10:   fwd_rs2 = bus.memwb_result_in;
            default: fwd_rs2 = bus.rs2_data_in;
         endcase
      end
   end

   assign bus.ready_out = !valid_q || bus.ready_in;
   assign load          = bus.valid_in && bus.ready_out && !bus.flush_in;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: data registers are reset too, so outputs read zero (never X) after reset.
         valid_q <= 1'b0;
         op_b_q  <= '0;
         store_q <= '0;
         imm_q   <= '0;
         err_q   <= 1'b0;
      end else if (bus.flush_in) begin
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q <= 1'b1;
         op_b_q  <= bus.imm_sel_in ? imm : fwd_rs2;
         store_q <= fwd_rs2;
         imm_q   <= imm;
         err_q   <= fmt_err;
      end else if (bus.ready_in) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.valid_out       = valid_q;
   assign bus.op_b_out        = op_b_q;
   assign bus.store_data_out  = store_q;
   assign bus.trace_imm       = imm_q;
   assign bus.imm_fmt_err_out = err_q;
endmodule
